// File: rtl/sm83_regfile_ram.sv
// sm83_regfile_ram: RAM-backed SM83 register file (B,C,D,E,H,L,A,F,PC,SP,IR,IE).
// The storage array has no reset, so it can map onto distributed or block RAM.
// After rst_n is released, an init sequencer writes each entry's reset value, one
// entry per cycle. Supports 8/16-bit access, RD_PORTS read ports with one-cycle
// latency, and optional same-cycle write-to-read forwarding.
module sm83_regfile_ram #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 16,
  parameter int RD_PORTS = 2,
  parameter logic [2*DATA_W-1:0] PC_INIT = 16'h0100,
  parameter logic [2*DATA_W-1:0] SP_INIT = 16'hFFFE,
  parameter int FWD_EN = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           ready,
  input  logic                           wr_en,
  input  logic                           wr_pair,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [2*DATA_W-1:0]            wr_data,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS-1:0]            rd_pair,
  input  logic [RD_PORTS*AW-1:0]         rd_addr,
  output logic [RD_PORTS*2*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic                           err_busy
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_next_s;
  logic [AW-1:0]       init_idx_r, init_idx_next_s;
  logic                ready_r;
  logic                err_busy_r;
  logic [DATA_W-1:0]   mem_r [NUM_REGS];

  // Two write lanes: lane0 carries the single/even byte, lane1 the odd byte of a pair.
  logic                lane0_en_s, lane1_en_s;
  logic [AW-1:0]       lane0_addr_s, lane1_addr_s;
  logic [DATA_W-1:0]   lane0_data_s, lane1_data_s;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < NUM_REGS);
  endfunction

  function automatic logic [AW-1:0] even_of(input logic [AW-1:0] a);
    return {a[AW-1:1], 1'b0};
  endfunction

  function automatic logic [AW-1:0] odd_of(input logic [AW-1:0] a);
    return {a[AW-1:1], 1'b1};
  endfunction

  // Reset value of an entry: PC and SP halves come from parameters, everything else is zero.
  function automatic logic [DATA_W-1:0] init_value(input logic [AW-1:0] idx);
    logic [DATA_W-1:0] v;
    case (32'(idx))
      32'd8:   v = PC_INIT[2*DATA_W-1:DATA_W];
      32'd9:   v = PC_INIT[DATA_W-1:0];
      32'd10:  v = SP_INIT[2*DATA_W-1:DATA_W];
      32'd11:  v = SP_INIT[DATA_W-1:0];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Byte seen by a read: zero when out of range, otherwise the in-flight write
  // when forwarding is enabled, otherwise the stored value.
  function automatic logic [DATA_W-1:0] pick(
    input logic [AW-1:0]     a,
    input logic [DATA_W-1:0] stored,
    input logic              l0_en,
    input logic [AW-1:0]     l0_addr,
    input logic [DATA_W-1:0] l0_data,
    input logic              l1_en,
    input logic [AW-1:0]     l1_addr,
    input logic [DATA_W-1:0] l1_data
  );
    logic [DATA_W-1:0] b;
    if (!in_range(a)) begin
      b = '0;
    end else if ((FWD_EN != 0) && l0_en && (l0_addr == a)) begin
      b = l0_data;
    end else if ((FWD_EN != 0) && l1_en && (l1_addr == a)) begin
      b = l1_data;
    end else begin
      b = stored;
    end
    return b;
  endfunction

  // Next-state logic: INIT walks every entry once, then RUN holds until reset.
  always_comb begin
    state_next_s    = state_r;
    init_idx_next_s = init_idx_r;
    case (state_r)
      ST_INIT: begin
        if (32'(init_idx_r) == NUM_REGS - 1) begin
          state_next_s    = ST_RUN;
          init_idx_next_s = '0;
        end else begin
          init_idx_next_s = init_idx_r + AW'(1);
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
      end
      default: begin
        state_next_s    = ST_INIT;
        init_idx_next_s = '0;
      end
    endcase
  end

  // Sequencer state, ready flag and busy-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_idx_r <= '0;
      ready_r    <= 1'b0;
      err_busy_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      init_idx_r <= init_idx_next_s;
      ready_r    <= (state_next_s == ST_RUN);
      err_busy_r <= !ready_r && (wr_en || (|rd_en));
    end
  end

  // Write lane selection: the init sequencer owns the RAM until ready, then user writes.
  always_comb begin
    lane0_en_s   = 1'b0;
    lane0_addr_s = '0;
    lane0_data_s = '0;
    lane1_en_s   = 1'b0;
    lane1_addr_s = '0;
    lane1_data_s = '0;
    if (state_r == ST_INIT) begin
      lane0_en_s   = 1'b1;
      lane0_addr_s = init_idx_r;
      lane0_data_s = init_value(init_idx_r);
    end else if (ready_r && wr_en) begin
      if (wr_pair) begin
        lane0_addr_s = even_of(wr_addr);
        lane0_data_s = wr_data[2*DATA_W-1:DATA_W];
        lane0_en_s   = in_range(even_of(wr_addr));
        lane1_addr_s = odd_of(wr_addr);
        lane1_data_s = wr_data[DATA_W-1:0];
        lane1_en_s   = in_range(odd_of(wr_addr));
      end else begin
        lane0_addr_s = wr_addr;
        lane0_data_s = wr_data[DATA_W-1:0];
        lane0_en_s   = in_range(wr_addr);
      end
    end else begin
      lane0_en_s = 1'b0;
      lane1_en_s = 1'b0;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (lane0_en_s) begin
      mem_r[lane0_addr_s] <= lane0_data_s;
    end
    if (lane1_en_s) begin
      mem_r[lane1_addr_s] <= lane1_data_s;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]       addr_s, hi_addr_s, lo_addr_s;
    logic [DATA_W-1:0]   hi_byte_s, lo_byte_s;
    logic [2*DATA_W-1:0] data_next_s, data_r;
    logic                accept_s, valid_r;

    assign addr_s   = rd_addr[p*AW +: AW];
    assign accept_s = ready_r & rd_en[p];

    // Resolve this port's bytes, merging per byte with any same-cycle write.
    always_comb begin
      hi_addr_s = even_of(addr_s);
      if (rd_pair[p]) begin
        lo_addr_s = odd_of(addr_s);
      end else begin
        lo_addr_s = addr_s;
      end
      hi_byte_s = pick(hi_addr_s, mem_r[hi_addr_s], lane0_en_s, lane0_addr_s, lane0_data_s,
                       lane1_en_s, lane1_addr_s, lane1_data_s);
      lo_byte_s = pick(lo_addr_s, mem_r[lo_addr_s], lane0_en_s, lane0_addr_s, lane0_data_s,
                       lane1_en_s, lane1_addr_s, lane1_data_s);
      if (rd_pair[p]) begin
        data_next_s = {hi_byte_s, lo_byte_s};
      end else begin
        data_next_s = {{DATA_W{1'b0}}, lo_byte_s};
      end
    end

    // Port output register: one-cycle latency, data held until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        data_r  <= '0;
      end else begin
        valid_r <= accept_s;
        if (accept_s) begin
          data_r <= data_next_s;
        end
      end
    end

    assign rd_valid[p]                       = valid_r;
    assign rd_data[p*2*DATA_W +: 2*DATA_W]   = data_r;
  end

  assign ready    = ready_r;
  assign err_busy = err_busy_r;

endmodule

// File: tb/tb_sm83_regfile_ram.sv
// Testbench for sm83_regfile_ram: default build, a FWD_EN=0 build sharing the same
// stimulus, and a 3-port / 14-entry build for multiport and out-of-range cases.
`timescale 1ns/1ps
module tb_sm83_regfile_ram;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for dut0 (forwarding) and dut1 (no forwarding)
  logic        we, wp;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic [1:0]  re, rp;
  logic [7:0]  ra;
  logic        ready0, ready1, eb0, eb1;
  logic [1:0]  rv0, rv1;
  logic [31:0] rd0, rd1;

  // dut2: 3 read ports, 14 entries
  logic        we2, wp2;
  logic [3:0]  wa2;
  logic [15:0] wd2;
  logic [2:0]  re2, rp2;
  logic [11:0] ra2;
  logic        ready2, eb2;
  logic [2:0]  rv2;
  logic [47:0] rd2;

  sm83_regfile_ram dut0 (
    .clk(clk), .rst_n(rst_n), .ready(ready0), .wr_en(we), .wr_pair(wp), .wr_addr(wa),
    .wr_data(wd), .rd_en(re), .rd_pair(rp), .rd_addr(ra), .rd_data(rd0), .rd_valid(rv0),
    .err_busy(eb0)
  );

  sm83_regfile_ram #(.FWD_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ready(ready1), .wr_en(we), .wr_pair(wp), .wr_addr(wa),
    .wr_data(wd), .rd_en(re), .rd_pair(rp), .rd_addr(ra), .rd_data(rd1), .rd_valid(rv1),
    .err_busy(eb1)
  );

  sm83_regfile_ram #(.RD_PORTS(3), .NUM_REGS(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .ready(ready2), .wr_en(we2), .wr_pair(wp2), .wr_addr(wa2),
    .wr_data(wd2), .rd_en(re2), .rd_pair(rp2), .rd_addr(ra2), .rd_data(rd2), .rd_valid(rv2),
    .err_busy(eb2)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: plain byte array plus each port's last returned value
  logic [7:0]  mm [16];
  logic [15:0] hold0 [2];
  logic [15:0] hold1 [2];

  typedef struct {
    logic        we;
    logic        wp;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  re;
    logic [1:0]  rp;
    logic [7:0]  ra;
    logic [1:0]  ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    mm[8]  = 8'h01;
    mm[9]  = 8'h00;
    mm[10] = 8'hFF;
    mm[11] = 8'hFE;
    for (int p = 0; p < 2; p++) begin
      hold0[p] = 16'h0000;
      hold1[p] = 16'h0000;
    end
  endtask

  function automatic logic [15:0] model_read(input logic pair, input logic [3:0] a);
    logic [3:0] e;
    e = {a[3:1], 1'b0};
    if (pair) return {mm[e], mm[e + 4'd1]};
    return {8'h00, mm[a]};
  endfunction

  task automatic model_write(input logic pair, input logic [3:0] a, input logic [15:0] d);
    if (pair) begin
      mm[{a[3:1], 1'b0}] = d[15:8];
      mm[{a[3:1], 1'b1}] = d[7:0];
    end else begin
      mm[a] = d[7:0];
    end
  endtask

  // One RUN-mode cycle on dut0/dut1, checked against the model.
  // No-forwarding view reads before the write lands, forwarding view after.
  task automatic step(input logic we_i, input logic wp_i, input logic [3:0] wa_i,
                      input logic [15:0] wd_i, input logic [1:0] re_i, input logic [1:0] rp_i,
                      input logic [7:0] ra_i);
    we = we_i; wp = wp_i; wa = wa_i; wd = wd_i; re = re_i; rp = rp_i; ra = ra_i;
    for (int p = 0; p < 2; p++)
      if (re_i[p]) hold1[p] = model_read(rp_i[p], ra_i[p*4 +: 4]);
    if (we_i) model_write(wp_i, wa_i, wd_i);
    for (int p = 0; p < 2; p++)
      if (re_i[p]) hold0[p] = model_read(rp_i[p], ra_i[p*4 +: 4]);
    tick();
    check("rd_valid_fwd", rv0, re_i);
    check("rd_valid_nofwd", rv1, re_i);
    check("err_busy_run", eb0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      check("rd_data_fwd", rd0[p*16 +: 16], hold0[p]);
      check("rd_data_nofwd", rd1[p*16 +: 16], hold1[p]);
    end
    we = 1'b0; re = 2'b00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wp = 1'b0; wa = 4'd0; wd = 16'h0000; re = 2'b00; rp = 2'b00; ra = 8'h00;
    we2 = 1'b0; wp2 = 1'b0; wa2 = 4'd0; wd2 = 16'h0000; re2 = 3'b000; rp2 = 3'b000; ra2 = 12'h000;
    model_reset();

    vt[0]  = '{1'b1, 1'b0, 4'd0, 16'h0012, 2'b00, 2'b00, 8'h00, 2'b00, 32'h0000_0000};
    vt[1]  = '{1'b1, 1'b0, 4'd1, 16'h0034, 2'b00, 2'b00, 8'h00, 2'b00, 32'h0000_0000};
    vt[2]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b01, 2'b01, 8'h00, 2'b01, 32'h0000_1234};
    vt[3]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 2'b00, 8'h00, 2'b00, 32'h0000_1234};
    vt[4]  = '{1'b1, 1'b1, 4'd5, 16'hABCD, 2'b00, 2'b00, 8'h00, 2'b00, 32'h0000_1234};
    vt[5]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b11, 2'b00, 8'h54, 2'b11, 32'h00CD_00AB};
    vt[6]  = '{1'b1, 1'b0, 4'd6, 16'h005A, 2'b01, 2'b00, 8'h06, 2'b01, 32'h00CD_005A};
    vt[7]  = '{1'b1, 1'b0, 4'd2, 16'h0011, 2'b00, 2'b00, 8'h00, 2'b00, 32'h00CD_005A};
    vt[8]  = '{1'b1, 1'b0, 4'd3, 16'h0077, 2'b10, 2'b10, 8'h20, 2'b10, 32'h1177_005A};
    vt[9]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b11, 2'b01, 8'h73, 2'b11, 32'h0000_1177};
    vt[10] = '{1'b1, 1'b1, 4'd8, 16'h1234, 2'b11, 2'b11, 8'hA9, 2'b11, 32'hFFFE_1234};
    vt[11] = '{1'b1, 1'b0, 4'd9, 16'h0056, 2'b11, 2'b01, 8'h88, 2'b11, 32'h0012_1256};

    // Reset state
    repeat (3) tick();
    check("reset_ready", ready0, 1'b0);
    check("reset_rd_valid", rv0, 2'b00);
    check("reset_rd_data", rd0, 32'h0);
    check("reset_err_busy", eb0, 1'b0);
    check("reset_rd_data_3p", rd2, 48'h0);

    // T1: init takes NUM_REGS cycles after release
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t1_ready", ready0, (i == 16));
      check("t1_ready_nofwd", ready1, (i == 16));
      check("t1_ready_14", ready2, (i >= 14));
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 2'b11, 8'hA8);
    check("t1_pc_sp", rd0, 32'hFFFE_0100);
    step(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 2'b11, 8'h20);
    check("t1_bc_de", rd0, 32'h0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 2'b11, 8'h64);
    check("t1_hl_af", rd0, 32'h0);

    // T2/T3: directed table
    for (int i = 0; i < 12; i++) begin
      step(vt[i].we, vt[i].wp, vt[i].wa, vt[i].wd, vt[i].re, vt[i].rp, vt[i].ra);
      check("tbl_valid", rv0, vt[i].ev);
      check("tbl_data", rd0, vt[i].ed);
      if (i == 6) check("t3_nofwd_old_a", rd1[15:0], 16'h0000);
      if (i == 8) check("t3_nofwd_old_e", rd1[31:16], 16'h1100);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
           2'($urandom), 2'($urandom), 8'($urandom));
    end

    // T6: three ports on HL, then out-of-range accesses
    we2 = 1'b1; wp2 = 1'b1; wa2 = 4'd5; wd2 = 16'h9A3C;
    tick();
    we2 = 1'b0;
    re2 = 3'b111; rp2 = 3'b111; ra2 = {4'd4, 4'd5, 4'd4};
    tick();
    check("t6_valid", rv2, 3'b111);
    check("t6_err_busy", eb2, 1'b0);
    for (int p = 0; p < 3; p++) check("t6_hl", rd2[p*16 +: 16], 16'h9A3C);
    re2 = 3'b000; we2 = 1'b1; wp2 = 1'b0; wa2 = 4'd15; wd2 = 16'h0077;
    tick();
    wp2 = 1'b1; wa2 = 4'd14; wd2 = 16'hBEEF;
    tick();
    we2 = 1'b0;
    re2 = 3'b111; rp2 = 3'b010; ra2 = {4'd1, 4'd14, 4'd15};
    tick();
    check("t6_oor_valid", rv2, 3'b111);
    check("t6_oor_data", rd2, 48'h0);
    rp2 = 3'b000; ra2 = {4'd13, 4'd0, 4'd12};
    tick();
    check("t6_alias_data", rd2, 48'h0);
    re2 = 3'b000;

    // T5/T4: reset with reads in flight, then requests during init
    re = 2'b11; rp = 2'b11; ra = 8'hA8;
    tick();
    check("t5_inflight_valid", rv0, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", rv0, 2'b00);
    check("t5_async_valid_nofwd", rv1, 2'b00);
    check("t5_async_data", rd0, 32'h0);
    check("t5_async_ready", ready0, 1'b0);
    re = 2'b00;
    tick();
    rst_n = 1'b1;
    model_reset();
    repeat (5) tick();
    we = 1'b1; wp = 1'b1; wa = 4'd0; wd = 16'hEEEE; re = 2'b11; rp = 2'b11; ra = 8'h00;
    tick();
    check("t4_err_busy", eb0, 1'b1);
    check("t4_err_busy_nofwd", eb1, 1'b1);
    check("t4_no_valid", rv0, 2'b00);
    we = 1'b0; re = 2'b00;
    tick();
    check("t4_err_busy_clear", eb0, 1'b0);
    begin
      int k;
      k = 0;
      while (ready0 !== 1'b1 && k < 40) begin
        tick();
        k++;
      end
      check("t5_ready_timeout", ready0, 1'b1);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 2'b11, 8'h80);
    check("t5_bc_pc", rd0, 32'h0100_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
